// File: rtl/mvau_defn_pkg.sv
// Shared definitions for the MVU processing-element datapath.
// Holds the accumulation FSM state type and a parameter sanity helper.
package mvau_defn;

    typedef enum logic {IDLE, ACC} acc_state_t;

    function automatic bit acc_params_ok(input int ta, input int to, input int sf, input int nf);
        return (ta >= to) && (sf >= 1) && (nf >= 1);
    endfunction

endpackage

// File: rtl/mvu_fold_cnt.sv
// Wrap-around fold counter: counts 0..MAX-1 on en, flags the final count.
module mvu_fold_cnt #(
    parameter int MAX = 4
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 en,
    input  logic                                 clear,
    output logic [((MAX > 1) ? $clog2(MAX) : 1)-1:0] cnt,
    output logic                                 at_max
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

    assign at_max = (cnt == W'(MAX - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_max ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mvu_pe_acc_ctrl.sv
// Per-PE accumulation sequencer: sums SF adder-tree beats into one neuron
// and presents it on a valid/ready output, counting NF neurons per matrix.
module mvu_pe_acc_ctrl
    import mvau_defn::*;
#(
    parameter int TO = 16,
    parameter int TA = 24,
    parameter int SF = 4,
    parameter int NF = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 in_v,
    output logic                 in_rdy,
    input  logic signed [TO-1:0] in_add,
    output logic                 out_v,
    input  logic                 out_rdy,
    output logic signed [TA-1:0] out_acc,
    output logic                 out_last,
    output logic                 busy
);

    localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;

    if (!acc_params_ok(TA, TO, SF, NF)) begin : g_param_chk
        $error("mvu_pe_acc_ctrl: requires TA >= TO, SF >= 1, NF >= 1");
    end

    acc_state_t          state, state_next;
    logic [SFW-1:0]      sf_cnt;
    logic [NFW-1:0]      nf_cnt_unused;
    logic                sf_at_max, nf_at_max;
    logic                beat, last_beat;
    logic signed [TA-1:0] add_ext, acc, acc_next;

    // Only the completing beat stalls; earlier folds of the next neuron proceed.
    assign in_rdy    = !(out_v && !out_rdy && (sf_cnt == SFW'(SF - 1)));
    assign beat      = in_v && in_rdy;
    assign last_beat = beat && sf_at_max;
    assign add_ext   = TA'(in_add);
    assign busy      = (state == ACC);

    mvu_fold_cnt #(.MAX(SF)) u_sf_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (beat),
        .clear   (1'b0),
        .cnt     (sf_cnt),
        .at_max  (sf_at_max)
    );

    mvu_fold_cnt #(.MAX(NF)) u_nf_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (last_beat),
        .clear   (1'b0),
        .cnt     (nf_cnt_unused),
        .at_max  (nf_at_max)
    );

    always_comb begin
        state_next = state;
        acc_next   = (state == IDLE) ? add_ext : acc + add_ext;
        case (state)
            IDLE: if (beat && !sf_at_max) state_next = ACC;
            ACC:  if (last_beat)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_next;
            if (beat) acc <= acc_next;
        end
    end

    // A new result overwrites an accepted one in the same cycle, keeping out_v high.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_v    <= 1'b0;
            out_acc  <= '0;
            out_last <= 1'b0;
        end else if (last_beat) begin
            out_v    <= 1'b1;
            out_acc  <= acc_next;
            out_last <= nf_at_max;
        end else if (out_v && out_rdy) begin
            out_v    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvu_pe_acc_ctrl.sv
// Directed bench for mvu_pe_acc_ctrl: main, narrow-wrap and SF=1 configurations.
module tb_mvu_pe_acc_ctrl;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b1;
    logic [2:0]        in_v_bus = '0;
    logic signed [7:0] in_add = '0;
    logic              m_out_rdy = 1'b1;

    logic              m_in_rdy, m_out_v, m_out_last, m_busy;
    logic signed [15:0] m_out_acc;
    logic              w_in_rdy, w_out_v, w_out_last, w_busy;
    logic signed [8:0] w_out_acc;
    logic              s_in_rdy, s_out_v, s_out_last, s_busy;
    logic signed [15:0] s_out_acc;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 aclk = ~aclk;

    mvu_pe_acc_ctrl #(.TO(8), .TA(16), .SF(4), .NF(2)) u_main (
        .aclk(aclk), .aresetn(aresetn), .in_v(in_v_bus[0]), .in_rdy(m_in_rdy),
        .in_add(in_add), .out_v(m_out_v), .out_rdy(m_out_rdy), .out_acc(m_out_acc),
        .out_last(m_out_last), .busy(m_busy)
    );

    mvu_pe_acc_ctrl #(.TO(8), .TA(9), .SF(4), .NF(2)) u_wrap (
        .aclk(aclk), .aresetn(aresetn), .in_v(in_v_bus[1]), .in_rdy(w_in_rdy),
        .in_add(in_add), .out_v(w_out_v), .out_rdy(1'b1), .out_acc(w_out_acc),
        .out_last(w_out_last), .busy(w_busy)
    );

    mvu_pe_acc_ctrl #(.TO(8), .TA(16), .SF(1), .NF(2)) u_sf1 (
        .aclk(aclk), .aresetn(aresetn), .in_v(in_v_bus[2]), .in_rdy(s_in_rdy),
        .in_add(in_add), .out_v(s_out_v), .out_rdy(1'b1), .out_acc(s_out_acc),
        .out_last(s_out_last), .busy(s_busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int sel);
        case (sel)
            0: return m_in_rdy;
            1: return w_in_rdy;
            default: return s_in_rdy;
        endcase
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Present one beat to instance sel and return 1 time unit after it is taken.
    task automatic send(input int sel, input logic signed [7:0] v);
        int n = 0;
        in_add = v;
        in_v_bus[sel] = 1'b1;
        while (!rdy_of(sel) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("rdy_timeout", 0, 1);
        tick();
        in_v_bus = '0;
    endtask

    initial begin
        // asynchronous reset, mid-cycle
        #2 aresetn = 1'b0;
        #1;
        check("rst_in_rdy",   m_in_rdy, 1);
        check("rst_out_v",    m_out_v, 0);
        check("rst_out_acc",  m_out_acc, 0);
        check("rst_out_last", m_out_last, 0);
        check("rst_busy",     m_busy, 0);
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        tick();

        // neuron 1: 10 - 3 + 5 + 7 = 19
        send(0, 8'sd10);
        check("n1_busy", m_busy, 1);
        send(0, -8'sd3);
        send(0, 8'sd5);
        check("n1_pre_v", m_out_v, 0);
        send(0, 8'sd7);
        check("n1_v", m_out_v, 1);
        check("n1_acc", m_out_acc, 19);
        check("n1_last", m_out_last, 0);
        check("n1_idle", m_busy, 0);

        // neuron 2: 4, last of matrix
        send(0, 8'sd1);
        check("n2_v_drop", m_out_v, 0);
        send(0, 8'sd1);
        send(0, 8'sd1);
        send(0, 8'sd1);
        check("n2_v", m_out_v, 1);
        check("n2_acc", m_out_acc, 4);
        check("n2_last", m_out_last, 1);

        // neuron 3: NF wrap
        for (int i = 0; i < 4; i++) send(0, 8'sd2);
        check("n3_acc", m_out_acc, 8);
        check("n3_last", m_out_last, 0);

        // neuron 4 under backpressure
        m_out_rdy = 1'b0;
        send(0, 8'sd3);
        send(0, 8'sd3);
        send(0, 8'sd3);
        check("bp_in_rdy", m_in_rdy, 0);
        in_add = 8'sd3;
        in_v_bus[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_hold_v", m_out_v, 1);
            check("bp_hold_acc", m_out_acc, 8);
            check("bp_hold_rdy", m_in_rdy, 0);
        end
        m_out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", m_in_rdy, 1);
        tick();
        in_v_bus = '0;
        check("bp_new_v", m_out_v, 1);
        check("bp_new_acc", m_out_acc, 12);
        check("bp_new_last", m_out_last, 1);
        tick();
        check("bp_drain_v", m_out_v, 0);

        // reset mid-neuron discards partial sum and clears counters
        send(0, 8'sd50);
        send(0, 8'sd50);
        #2 aresetn = 1'b0;
        #1;
        check("mrst_busy", m_busy, 0);
        check("mrst_acc", m_out_acc, 0);
        check("mrst_in_rdy", m_in_rdy, 1);
        #3 aresetn = 1'b1;
        tick();
        send(0, 8'sd1);
        send(0, 8'sd2);
        send(0, 8'sd3);
        send(0, 8'sd4);
        check("mrst_n_acc", m_out_acc, 10);
        check("mrst_n_last", m_out_last, 0);

        // bubbles: 5 - 7 + 100 + 2 = 100
        send(0, 8'sd5);
        tick();
        check("bub_busy", m_busy, 1);
        send(0, -8'sd7);
        tick();
        tick();
        send(0, 8'sd100);
        tick();
        check("bub_pre_v", m_out_v, 0);
        send(0, 8'sd2);
        check("bub_v", m_out_v, 1);
        check("bub_acc", m_out_acc, 100);
        check("bub_last", m_out_last, 1);

        // 9-bit wrap: 4*127 = 508 -> -4; 4*(-128) = -512 -> 0
        for (int i = 0; i < 4; i++) send(1, 8'sd127);
        check("wrap_pos_v", w_out_v, 1);
        check("wrap_pos_acc", w_out_acc, -4);
        for (int i = 0; i < 4; i++) send(1, -8'sd128);
        check("wrap_neg_acc", w_out_acc, 0);
        check("wrap_neg_last", w_out_last, 1);

        // SF=1: every beat is a result
        send(2, -8'sd5);
        check("sf1_a_v", s_out_v, 1);
        check("sf1_a_acc", s_out_acc, -5);
        check("sf1_a_last", s_out_last, 0);
        check("sf1_a_busy", s_busy, 0);
        send(2, 8'sd9);
        check("sf1_b_acc", s_out_acc, 9);
        check("sf1_b_last", s_out_last, 1);
        send(2, -8'sd1);
        check("sf1_c_v", s_out_v, 1);
        check("sf1_c_acc", s_out_acc, -1);
        check("sf1_c_last", s_out_last, 0);
        tick();
        check("sf1_drain_v", s_out_v, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
